// File: rtl/dmem_arbiter_rv32i.sv
// Two-port arbiter (core C, external X) in front of the single-port RV32I data memory.
// Build option DMEM_ARB_RR_EN: round-robin between C and X instead of core priority with a starvation guard.
module dmem_arbiter_rv32i #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_storetype,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              core_stall,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [1:0]        x_storetype,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [31:0]       x_wdata,
    input  logic              x_lock,
    output logic              x_gnt,
    output logic              x_rvalid,
    output logic [31:0]       x_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_storetype,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN_C, OWN_X, LOCK_X} state_t;

    state_t state_q, state_d;
    logic   rd_pend_q;
    logic   rd_owner_q;

`ifdef DMEM_ARB_RR_EN
    logic last_x_q;
`else
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
    logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

    // Grants are forced low during reset so every output reads 0 while rst is high.
    always_comb begin
        c_gnt = 1'b0;
        x_gnt = 1'b0;
        if (!rst) begin
            if (state_q == LOCK_X) begin
                x_gnt = x_req;
`ifdef DMEM_ARB_RR_EN
            end else if (c_req && x_req) begin
                c_gnt = last_x_q;
                x_gnt = ~last_x_q;
            end else begin
                c_gnt = c_req;
                x_gnt = x_req;
            end
`else
            end else if (x_req && (wait_cnt_q == WAIT_MAX)) begin
                x_gnt = 1'b1;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else begin
                x_gnt = x_req;
            end
`endif
        end
    end

    always_comb begin
        if (c_gnt) begin
            state_d = OWN_C;
        end else if (x_gnt) begin
            state_d = x_lock ? LOCK_X : OWN_X;
        end else if (state_q == LOCK_X && x_lock) begin
            state_d = LOCK_X;
        end else begin
            state_d = IDLE;
        end
    end

`ifndef DMEM_ARB_RR_EN
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (x_gnt) begin
            wait_cnt_d = '0;
        end else if (x_req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_x_q   <= 1'b1;
`else
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= (c_gnt & ~c_we) | (x_gnt & ~x_we);
            rd_owner_q <= x_gnt;
`ifdef DMEM_ARB_RR_EN
            if (c_gnt || x_gnt) begin
                last_x_q <= x_gnt;
            end
`else
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        mem_we        = 1'b0;
        mem_storetype = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (c_gnt) begin
            mem_we        = c_we;
            mem_storetype = c_storetype;
            mem_addr      = c_addr;
            mem_wdata     = c_wdata;
        end else if (x_gnt) begin
            mem_we        = x_we;
            mem_storetype = x_storetype;
            mem_addr      = x_addr;
            mem_wdata     = x_wdata;
        end
    end

    assign mem_en     = c_gnt | x_gnt;
    assign core_stall = ~rst & c_req & ~c_gnt;
    assign c_rvalid   = ~rst & rd_pend_q & ~rd_owner_q;
    assign x_rvalid   = ~rst & rd_pend_q & rd_owner_q;
    assign c_rdata    = c_rvalid ? mem_rdata : '0;
    assign x_rdata    = x_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter_rv32i.sv
// Scoreboard bench for dmem_arbiter_rv32i; load returns are queued at grant time and matched on rvalid.
// Covers the DMEM_ARB_RR_EN build when the macro is defined for both files.
module tb_dmem_arbiter_rv32i;

    localparam int unsigned MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, x_req, x_we, x_lock;
    logic [1:0]  c_storetype, x_storetype;
    logic [31:0] c_addr, c_wdata, x_addr, x_wdata;
    logic        c_gnt, c_rvalid, core_stall, x_gnt, x_rvalid;
    logic [31:0] c_rdata, x_rdata;
    logic        mem_en, mem_we;
    logic [1:0]  mem_storetype;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter_rv32i #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_storetype(c_storetype), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
        .x_req(x_req), .x_we(x_we), .x_storetype(x_storetype), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_lock(x_lock), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_storetype(mem_storetype), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, garbage on the bus when no read was issued.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we)
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr]
                       : (mem_addr == 32'h10) ? 32'hDEADBEEF : ~mem_addr;
        else
            mem_rdata <= $urandom;
    end

    typedef struct {logic is_x; logic [31:0] data; int unsigned due;} rsp_t;
    rsp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("c_rvalid", {31'd0, c_rvalid}, {31'd0, ~e.is_x});
            chk("x_rvalid", {31'd0, x_rvalid}, {31'd0, e.is_x});
            chk("c_rdata", c_rdata, e.is_x ? 32'd0 : e.data);
            chk("x_rdata", x_rdata, e.is_x ? e.data : 32'd0);
        end else begin
            chk("c_rvalid_idle", {31'd0, c_rvalid}, 32'd0);
            chk("x_rvalid_idle", {31'd0, x_rvalid}, 32'd0);
            chk("c_rdata_idle", c_rdata, 32'd0);
            chk("x_rdata_idle", x_rdata, 32'd0);
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks the cycle and returns at next posedge+1.
    task automatic cycle(input logic ec, input logic ex, input logic [31:0] edata);
        @(negedge clk);
        chk("c_gnt", {31'd0, c_gnt}, {31'd0, ec});
        chk("x_gnt", {31'd0, x_gnt}, {31'd0, ex});
        chk("core_stall", {31'd0, core_stall}, {31'd0, c_req & ~ec});
        chk("mem_en", {31'd0, mem_en}, {31'd0, ec | ex});
        if (ec) begin
            chk("mem_addr_c", mem_addr, c_addr);
            chk("mem_we_c", {31'd0, mem_we}, {31'd0, c_we});
            if (!c_we) sb.push_back('{is_x: 1'b0, data: edata, due: cyc + 1});
        end
        if (ex) begin
            chk("mem_addr_x", mem_addr, x_addr);
            chk("mem_we_x", {31'd0, mem_we}, {31'd0, x_we});
            if (x_we) begin
                chk("mem_wdata_x", mem_wdata, x_wdata);
                chk("mem_storetype_x", {30'd0, mem_storetype}, {30'd0, x_storetype});
            end else begin
                sb.push_back('{is_x: 1'b1, data: edata, due: cyc + 1});
            end
        end
        check_rsp();
        @(posedge clk);
        #1;
    endtask

    // Both ports store continuously; expected winner derived from the arbitration rules.
    task automatic contend(input int n, input int unsigned wait0, input logic last_x0);
        int unsigned w;
        logic lx, xw;
        w  = wait0;
        lx = last_x0;
        c_req = 1'b1; c_we = 1'b1; c_storetype = 2'b10; c_addr = 32'h40; c_wdata = 32'h1111_0040;
        x_req = 1'b1; x_we = 1'b1; x_storetype = 2'b10; x_addr = 32'h44; x_wdata = 32'h2222_0044;
        x_lock = 1'b0;
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
            xw = ~lx;
            lx = xw;
`else
            xw = (w == MAX_WAIT);
            w  = xw ? 0 : ((w < MAX_WAIT) ? w + 1 : w);
`endif
            cycle(~xw, xw, 32'd0);
        end
        c_req = 1'b0;
        x_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_storetype = 2'b00; c_addr = '0; c_wdata = '0;
        x_req = 1'b0; x_we = 1'b0; x_storetype = 2'b00; x_addr = '0; x_wdata = '0; x_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);

        // Core load alone
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        cycle(1'b1, 1'b0, 32'hDEADBEEF);
        c_req = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);

        // Contention; last grant was the core
        contend(20, 0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0);

        // Locked X burst of word stores, core load waits behind it
        x_req = 1'b1; x_lock = 1'b1; x_we = 1'b1; x_storetype = 2'b10;
        x_addr = 32'h20; x_wdata = 32'hA000_0020;
        cycle(1'b0, 1'b1, 32'd0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h24;
        for (int k = 1; k < 4; k++) begin
            x_addr  = 32'h20 + 32'(4 * k);
            x_wdata = 32'hA000_0020 + 32'(4 * k);
            cycle(1'b0, 1'b1, 32'd0);
        end
        x_req = 1'b0; x_lock = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'hA000_0024);
        c_req = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);

        // X load then core load back-to-back
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h28;
        cycle(1'b0, 1'b1, 32'hA000_0028);
        x_req = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        cycle(1'b1, 1'b0, 32'hDEADBEEF);
        c_req = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);

        // Reset mid-read, with the wait counter primed beforehand
        contend(5, 0, 1'b0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        cycle(1'b1, 1'b0, 32'hDEADBEEF);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_c_gnt", {31'd0, c_gnt}, 32'd0);
        chk("rst_x_gnt", {31'd0, x_gnt}, 32'd0);
        chk("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c_req = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);
        contend(10, 0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
